// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: single-outstanding memory end of the core dbus protocol.
// Accepts when idle and not held; answers with a one-cycle data_ok LATENCY cycles after accept.
module dbus_sram_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] RESET_DATA = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dreq_valid_i,
    input  logic [31:0] dreq_addr_i,
    input  logic [2:0]  dreq_size_i,
    input  logic [3:0]  dreq_strobe_i,
    input  logic [31:0] dreq_data_i,
    input  logic        hold_i,
    output logic        dresp_addr_ok_o,
    output logic        dresp_data_ok_o,
    output logic [31:0] dresp_data_o,
    output logic        busy_o
);
    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          accept;
    logic [IW-1:0] idx;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   rdata_q;
    logic          unused_ok;

    // Size and the sub-word/upper address bits are deliberately ignored (aliasing).
    assign unused_ok = ^{dreq_size_i, dreq_addr_i[31:IW+2], dreq_addr_i[1:0]};

    assign idx             = dreq_addr_i[IW+1:2];
    assign dresp_addr_ok_o = rst_ni & dreq_valid_i & ~hold_i & (state_q == IDLE);
    assign accept          = dreq_valid_i & dresp_addr_ok_o;
    assign dresp_data_ok_o = (state_q == RESP);
    assign dresp_data_o    = (state_q == RESP) ? rdata_q : RESET_DATA;
    assign busy_o          = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage survives reset; read data is the pre-write word captured at the accept edge.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rdata_q <= mem[idx];
            for (int i = 0; i < 4; i++) begin
                if (dreq_strobe_i[i]) begin
                    mem[idx][8*i +: 8] <= dreq_data_i[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: LATENCY=2 instance for most scenarios, LATENCY=1 for back-to-back.
module tb_dbus_sram_responder;
    logic        clk;
    logic        rst_n;

    logic        valid0, hold0, addr_ok0, data_ok0, busy0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [2:0]  size0;
    logic [3:0]  strobe0;

    logic        valid1, hold1, addr_ok1, data_ok1, busy1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [2:0]  size1;
    logic [3:0]  strobe1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [1024];
    logic [3:0]  kn  [1024];

    dbus_sram_responder #(.DEPTH(1024), .LATENCY(2), .RESET_DATA(32'h0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .dreq_valid_i(valid0), .dreq_addr_i(addr0), .dreq_size_i(size0),
        .dreq_strobe_i(strobe0), .dreq_data_i(wdata0), .hold_i(hold0),
        .dresp_addr_ok_o(addr_ok0), .dresp_data_ok_o(data_ok0),
        .dresp_data_o(rdata0), .busy_o(busy0)
    );

    dbus_sram_responder #(.DEPTH(1024), .LATENCY(1), .RESET_DATA(32'h0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .dreq_valid_i(valid1), .dreq_addr_i(addr1), .dreq_size_i(size1),
        .dreq_strobe_i(strobe1), .dreq_data_i(wdata1), .hold_i(hold1),
        .dresp_addr_ok_o(addr_ok1), .dresp_data_ok_o(data_ok1),
        .dresp_data_o(rdata1), .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int idx;
        idx = int'(a[11:2]);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
        end
        kn[idx] = kn[idx] | s;
    endfunction

    // One full transaction on the LATENCY=2 instance; call at a negedge with hold0 low.
    task automatic access0(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           output logic [31:0] got);
        int          idx;
        int          n;
        logic [31:0] exp;
        logic        known;
        idx   = int'(a[11:2]);
        exp   = mdl[idx];
        known = (kn[idx] == 4'hF);
        valid0 = 1'b1; addr0 = a; strobe0 = s; wdata0 = d; size0 = 3'($urandom);
        #1;
        checks++;
        if (addr_ok0 !== 1'b1) begin
            failures++;
            $display("FAIL acc_addr_ok addr=%h got=%b want=1", a, addr_ok0);
        end
        @(posedge clk);
        model_write(a, s, d);
        @(negedge clk);
        valid0 = 1'b0; strobe0 = 4'h0;
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL acc_busy addr=%h got=%b want=1", a, busy0);
        end
        n = 1;
        while (data_ok0 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        got = rdata0;
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL acc_latency addr=%h got=%0d want=2", a, n);
        end
        if (known) begin
            checks++;
            if (rdata0 !== exp) begin
                failures++;
                $display("FAIL acc_data addr=%h got=%h want=%h", a, rdata0, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (data_ok0 !== 1'b0 || rdata0 !== 32'h0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL acc_one_cycle addr=%h data_ok=%b data=%h busy=%b want 0/0/0",
                     a, data_ok0, rdata0, busy0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid0 = 1'b1; addr0 = 32'h0; strobe0 = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (addr_ok0 !== 1'b0 || data_ok0 !== 1'b0 || rdata0 !== 32'h0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state addr_ok=%b data_ok=%b data=%h busy=%b want 0/0/0/0",
                     addr_ok0, data_ok0, rdata0, busy0);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (addr_ok0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_addr_ok got=%b want=1", addr_ok0);
        end
        valid0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_word();
        logic [31:0] got;
        access0(32'h10, 4'hF, 32'h12345678, got);
        access0(32'h10, 4'h0, 32'h0, got);
        checks++;
        if (got !== 32'h12345678) begin
            failures++;
            $display("FAIL full_word_read got=%h want=12345678", got);
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] got;
        access0(32'h10, 4'b0100, 32'h00AB0000, got);
        checks++;
        if (got !== 32'h12345678) begin
            failures++;
            $display("FAIL strobe_write_old got=%h want=12345678", got);
        end
        access0(32'h10, 4'h0, 32'h0, got);
        checks++;
        if (got !== 32'h12AB5678) begin
            failures++;
            $display("FAIL strobe_read got=%h want=12AB5678", got);
        end
    endtask

    task automatic test_wrap_hold();
        logic [31:0] got;
        access0(32'h1000, 4'hF, 32'h5A5AC3C3, got);
        access0(32'h0, 4'h0, 32'h0, got);
        checks++;
        if (got !== 32'h5A5AC3C3) begin
            failures++;
            $display("FAIL wrap_alias got=%h want=5A5AC3C3", got);
        end
        hold0 = 1'b1;
        valid0 = 1'b1; addr0 = 32'h0; strobe0 = 4'h0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (addr_ok0 !== 1'b0 || busy0 !== 1'b0) begin
                failures++;
                $display("FAIL hold_refuse cyc=%0d addr_ok=%b busy=%b want 0/0", k, addr_ok0, busy0);
            end
            @(negedge clk);
        end
        hold0 = 1'b0;
        valid0 = 1'b0;
        access0(32'h0, 4'h0, 32'h0, got);
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] got;
        valid0 = 1'b1; addr0 = 32'h20; strobe0 = 4'hF; wdata0 = 32'hCAFEF00D;
        @(posedge clk);
        model_write(32'h20, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        valid0 = 1'b0; strobe0 = 4'h0;
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) rst_n = 1'b1;
            #1;
            checks++;
            if (data_ok0 !== 1'b0 || busy0 !== 1'b0) begin
                failures++;
                $display("FAIL abandon_no_data_ok cyc=%0d data_ok=%b busy=%b want 0/0", k, data_ok0, busy0);
            end
            @(negedge clk);
        end
        access0(32'h20, 4'h0, 32'h0, got);
        checks++;
        if (got !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL abandon_write_kept got=%h want=CAFEF00D", got);
        end
    endtask

    task automatic test_back_to_back();
        valid1 = 1'b1; addr1 = 32'h40; strobe1 = 4'hF; wdata1 = 32'hA5A50F0F;
        #1;
        checks++;
        if (addr_ok1 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_addr_ok got=%b want=1", addr_ok1);
        end
        @(negedge clk);
        strobe1 = 4'h0;
        // With LATENCY=1 the bus alternates RESP / accept-ready every cycle.
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (data_ok1 !== ((k % 2) == 0) || addr_ok1 !== ((k % 2) == 1) ||
                busy1 !== ((k % 2) == 0)) begin
                failures++;
                $display("FAIL b2b_pattern cyc=%0d data_ok=%b addr_ok=%b busy=%b", k, data_ok1, addr_ok1, busy1);
            end
            if (k >= 2 && (k % 2) == 0) begin
                checks++;
                if (rdata1 !== 32'hA5A50F0F) begin
                    failures++;
                    $display("FAIL b2b_data cyc=%0d got=%h want=A5A50F0F", k, rdata1);
                end
            end
            @(negedge clk);
        end
        valid1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [31:0] a;
        for (int w = 0; w < 16; w++) begin
            a = {$urandom_range(0, 1048575), 12'h0} | 32'(w * 4) | 32'($urandom_range(0, 3));
            access0(a, 4'hF, $urandom, got);
        end
        for (int t = 0; t < 40; t++) begin
            a = {$urandom_range(0, 1048575), 12'h0} | 32'($urandom_range(0, 15) * 4);
            access0(a, 4'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(0, 15)), $urandom, got);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mdl[i] = 32'h0;
            kn[i]  = 4'h0;
        end
        rst_n = 1'b0;
        valid0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; size0 = 3'h2; strobe0 = 4'h0; hold0 = 1'b0;
        valid1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0; size1 = 3'h2; strobe1 = 4'h0; hold1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_word();
        test_byte_strobe();
        test_wrap_hold();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
